// File: rtl/p2s_write_arbiter_if.sv
// p2s_write_arbiter_if
// Bundles the two word requesters, the flush request and the serial FIFO write
// port of p2s_write_arbiter.
//   req0/data0/ack0  requester 0 word handshake (ack0 pulses on capture)
//   req1/data1/ack1  requester 1 word handshake (ack1 pulses on capture)
//   flush_req        level request to empty the FIFO
//   full             FIFO full flag (write domain)
//   insert, dataIn   FIFO write strobe and serial bit
//   flush            one-cycle FIFO flush pulse
//   busy, word_cnt   status: not idle / words serialized since reset or flush
// Modports: master = requesters and FIFO side, slave = the arbiter.
interface p2s_write_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int CNTBITS = 16
);
    logic               req0;
    logic [WIDTH-1:0]   data0;
    logic               ack0;
    logic               req1;
    logic [WIDTH-1:0]   data1;
    logic               ack1;
    logic               flush_req;
    logic               full;
    logic               insert;
    logic               dataIn;
    logic               flush;
    logic               busy;
    logic [CNTBITS-1:0] word_cnt;

    modport master (
        output req0, data0, req1, data1, flush_req, full,
        input  ack0, ack1, insert, dataIn, flush, busy, word_cnt
    );

    modport slave (
        input  req0, data0, req1, data1, flush_req, full,
        output ack0, ack1, insert, dataIn, flush, busy, word_cnt
    );
endinterface

// File: rtl/p2s_write_arbiter.sv
// p2s_write_arbiter
// Round-robin arbiter between two parallel-word requesters that serializes the
// granted word MSB-first into a FIFO write port, honouring the FIFO full flag,
// and services flush requests between words.
// Ports:
//   clk_in  write-domain clock, all state changes on its rising edge
//   rst     asynchronous active-high reset
//   bus     p2s_write_arbiter_if.slave (requests, acks, FIFO port, status)
// Optional feature: define P2S_PARITY_EN to append one even-parity bit (XOR of
// the captured word) after the data bits of every word.
module p2s_write_arbiter #(
    parameter int WIDTH   = 8,
    parameter int CNTBITS = 16
) (
    input logic                clk_in,
    input logic                rst,
    p2s_write_arbiter_if.slave bus
);

    localparam int BCW = $clog2(WIDTH + 1);

`ifdef P2S_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        FLUSH  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd3
    } state_t;
`endif

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     shift_reg;
    logic [BCW-1:0]       bit_cnt;
    logic [CNTBITS-1:0]   cnt_q;
    // Set when requester 1 was served last, so requester 0 wins the next tie.
    logic                 last_grant;
    logic                 grant0;
    logic                 grant1;
    logic                 last_bit;
`ifdef P2S_PARITY_EN
    logic                 parity_bit;
`endif

    assign last_bit = (bit_cnt == BCW'(1));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush outranks word requests; a tie goes to the requester not served last.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.flush_req) begin
                    state_next = FLUSH;
                end else if (bus.req0 && (!bus.req1 || last_grant)) begin
                    grant0     = 1'b1;
                    state_next = SHIFT;
                end else if (bus.req1) begin
                    grant1     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (!bus.full && last_bit) begin
`ifdef P2S_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef P2S_PARITY_EN
            PARITY: begin
                if (!bus.full) begin
                    state_next = IDLE;
                end
            end
`endif
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            cnt_q      <= '0;
            last_grant <= 1'b1;
`ifdef P2S_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        shift_reg  <= bus.data0;
                        bit_cnt    <= BCW'(WIDTH);
                        last_grant <= 1'b0;
`ifdef P2S_PARITY_EN
                        parity_bit <= ^bus.data0;
`endif
                    end else if (grant1) begin
                        shift_reg  <= bus.data1;
                        bit_cnt    <= BCW'(WIDTH);
                        last_grant <= 1'b1;
`ifdef P2S_PARITY_EN
                        parity_bit <= ^bus.data1;
`endif
                    end
                end
                SHIFT: begin
                    if (!bus.full) begin
                        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                        bit_cnt   <= bit_cnt - 1'b1;
`ifndef P2S_PARITY_EN
                        if (last_bit) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`endif
                    end
                end
`ifdef P2S_PARITY_EN
                PARITY: begin
                    if (!bus.full) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                FLUSH:   cnt_q <= '0;
                default: ;
            endcase
        end
    end

    // Acks are masked by rst because the grant decode is combinational on req.
    assign bus.ack0 = grant0 && !rst;
    assign bus.ack1 = grant1 && !rst;

`ifdef P2S_PARITY_EN
    assign bus.insert = ((state == SHIFT) || (state == PARITY)) && !bus.full;
    assign bus.dataIn = (state == SHIFT)  ? shift_reg[WIDTH-1] :
                        (state == PARITY) ? parity_bit : 1'b0;
`else
    assign bus.insert = (state == SHIFT) && !bus.full;
    assign bus.dataIn = (state == SHIFT) ? shift_reg[WIDTH-1] : 1'b0;
`endif

    assign bus.flush    = (state == FLUSH);
    assign bus.busy     = (state != IDLE);
    assign bus.word_cnt = cnt_q;

endmodule
